mem_arbiter_rr: RTL and testbench

Parametrised N-port arbiter between requesters (instruction cache, data cache, DMA and similar) and the single IOCTRL memory interface. Each port issues read or write requests over a common req/ack handshake. A grant is chosen by round-robin or fixed priority, and one memory transaction runs at a time. An optional timeout aborts a stalled access and reports an error to the requester.

---
 rtl/mem_arbiter_rr.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin / fixed-priority arbiter in front of a single memory port.
// One transaction at a time, with an optional access timeout.
module mem_arbiter_rr #(
   parameter int NUM_PORTS = 4,
   parameter int ID_W      = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          ack,
   output logic [NUM_PORTS-1:0]          err,
   output logic [NUM_PORTS*DATA_W-1:0]   rdata,
   output logic                          mem_read,
   output logic                          mem_write,
   input  logic                          mem_ack,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_data_write,
   input  logic [DATA_W-1:0]             mem_data_read,
   output logic                          busy,
   output logic [ID_W-1:0]               grant_id
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_PORTS-1:0]             ack_q, ack_d;
   logic [NUM_PORTS-1:0]             err_q, err_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
   logic                             rd_q, rd_d;
   logic                             wr_q, wr_d;
   logic [ADDR_W-1:0]                maddr_q, maddr_d;
   logic [DATA_W-1:0]                mwdata_q, mwdata_d;
   logic                             busy_q, busy_d;
   logic [ID_W-1:0]                  gnt_q, gnt_d;
   logic [ID_W-1:0]                  ptr_q, ptr_d;
   logic [CW-1:0]                    cnt_q, cnt_d;

   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_a;
   logic [ID_W-1:0]                  rr_win;
   logic [ID_W-1:0]                  fp_win;
   logic [ID_W-1:0]                  win;
   logic                             tmo;

   assign addr_a  = addr;
   assign wdata_a = wdata;

   // Descending scans so the last hit is the closest one to the search start.
   always_comb begin
      int idx;
      idx    = 0;
      rr_win = '0;
      fp_win = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = (int'(ptr_q) + k) % NUM_PORTS;
         if (req[idx]) rr_win = ID_W'(idx);
      end
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i]) fp_win = ID_W'(i);
      end
      win = (PRIO_MODE != 0) ? fp_win : rr_win;
   end

   assign tmo = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      ack_d    = '0;
      err_d    = '0;
      rdata_d  = rdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = ACCESS;
               gnt_d   = win;
               maddr_d = addr_a[win];
               if (we[win]) mwdata_d = wdata_a[win];
               wr_d    = we[win];
               rd_d    = !we[win];
               cnt_d   = '0;
               if (PRIO_MODE == 0) ptr_d = win;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               state_d      = RESP;
               rd_d         = 1'b0;
               wr_d         = 1'b0;
               ack_d[gnt_q] = 1'b1;
               if (rd_q) rdata_d[gnt_q] = mem_data_read;
            end else if (tmo) begin
               state_d        = RESP;
               rd_d           = 1'b0;
               wr_d           = 1'b0;
               ack_d[gnt_q]   = 1'b1;
               err_d[gnt_q]   = 1'b1;
               rdata_d[gnt_q] = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         ack_q    <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         busy_q   <= 1'b0;
         gnt_q    <= '0;
         ptr_q    <= ID_W'(NUM_PORTS - 1);
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         busy_q   <= busy_d;
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ack            = ack_q;
   assign err            = err_q;
   assign rdata          = rdata_q;
   assign mem_read       = rd_q;
   assign mem_write      = wr_q;
   assign mem_addr       = maddr_q;
   assign mem_data_write = mwdata_q;
   assign busy           = busy_q;
   assign grant_id       = gnt_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a round-robin/timeout instance and a
// fixed-priority/no-timeout instance share all inputs.
module tb_mem_arbiter_rr;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        req;
   logic [3:0]        we;
   logic [3:0][31:0]  addr;
   logic [3:0][31:0]  wdata;
   logic              mem_ack;
   logic [31:0]       mem_data_read;

   logic [3:0]        rr_ack, rr_err;
   logic [3:0][31:0]  rr_rdata;
   logic              rr_rd, rr_wr, rr_busy;
   logic [31:0]       rr_maddr, rr_mwd;
   logic [1:0]        rr_gid;

   logic [3:0]        fp_ack, fp_err;
   logic [3:0][31:0]  fp_rdata;
   logic              fp_rd, fp_wr, fp_busy;
   logic [31:0]       fp_maddr, fp_mwd;
   logic [1:0]        fp_gid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_rr #(.NUM_PORTS(4), .ID_W(2), .ADDR_W(32), .DATA_W(32),
                    .PRIO_MODE(0), .TIMEOUT(5)) u_rr (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ack(rr_ack), .err(rr_err), .rdata(rr_rdata),
      .mem_read(rr_rd), .mem_write(rr_wr), .mem_ack(mem_ack),
      .mem_addr(rr_maddr), .mem_data_write(rr_mwd),
      .mem_data_read(mem_data_read), .busy(rr_busy), .grant_id(rr_gid)
   );

   mem_arbiter_rr #(.NUM_PORTS(4), .ID_W(2), .ADDR_W(32), .DATA_W(32),
                    .PRIO_MODE(1), .TIMEOUT(0)) u_fp (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .ack(fp_ack), .err(fp_err), .rdata(fp_rdata),
      .mem_read(fp_rd), .mem_write(fp_wr), .mem_ack(mem_ack),
      .mem_addr(fp_maddr), .mem_data_write(fp_mwd),
      .mem_data_read(mem_data_read), .busy(fp_busy), .grant_id(fp_gid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      int exp_g [5] = '{0, 1, 2, 3, 0};
      int fp_g  [3] = '{1, 1, 3};
      int rr_g  [3] = '{1, 3, 3};
      reset = 1'b0;
      req = '0;
      we = '0;
      addr = '0;
      wdata = '0;
      mem_ack = 1'b0;
      mem_data_read = '0;
      do_reset();

      chk("rst_ack", rr_ack, 0);
      chk("rst_busy", rr_busy, 0);
      chk("rst_rd", rr_rd, 0);
      chk("rst_gid", rr_gid, 0);
      chk("rst_rdata", rr_rdata, 0);

      // single read on port 2
      req = 4'b0100;
      addr[2] = 32'h100;
      step();
      chk("rd_strobe1", rr_rd, 1);
      chk("rd_addr", rr_maddr, 32'h100);
      chk("rd_gid", rr_gid, 2);
      chk("rd_busy", rr_busy, 1);
      chk("rd_ack_wait", rr_ack, 0);
      step();
      chk("rd_strobe2", rr_rd, 1);
      mem_ack = 1'b1;
      mem_data_read = 32'hDEADBEEF;
      step();
      chk("rd_ack", rr_ack, 4'b0100);
      chk("rd_err", rr_err, 0);
      chk("rd_rdata", rr_rdata[2], 32'hDEADBEEF);
      chk("rd_strobe_off", rr_rd, 0);
      mem_ack = 1'b0;
      req = '0;
      step();
      chk("rd_ack_pulse", rr_ack, 0);
      chk("rd_idle", rr_busy, 0);

      // write on port 0
      req = 4'b0001;
      we = 4'b0001;
      addr[0] = 32'h20;
      wdata[0] = 32'h5A5A5A5A;
      step();
      chk("wr_strobe", rr_wr, 1);
      chk("wr_nord", rr_rd, 0);
      chk("wr_addr", rr_maddr, 32'h20);
      chk("wr_data", rr_mwd, 32'h5A5A5A5A);
      chk("wr_gid", rr_gid, 0);
      mem_ack = 1'b1;
      step();
      chk("wr_ack", rr_ack, 4'b0001);
      chk("wr_rdata", rr_rdata[0], 0);
      chk("wr_strobe_off", rr_wr, 0);
      mem_ack = 1'b0;
      req = '0;
      we = '0;
      step();
      chk("wr_ack_pulse", rr_ack, 0);

      // round-robin fairness from reset, immediate mem_ack
      do_reset();
      req = 4'b1111;
      mem_ack = 1'b1;
      mem_data_read = 32'hCAFE0000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_gid", rr_gid, exp_g[i]);
         chk("rr_strobe", rr_rd, 1);
         chk("fp_gid_all", fp_gid, 0);
         step();
         chk("rr_ack", rr_ack, 4'b1 << exp_g[i]);
         chk("rr_rdata", rr_rdata[exp_g[i]], 32'hCAFE0000);
         step();
         chk("rr_gap", rr_ack, 0);
         chk("rr_idle", rr_busy, 0);
      end

      // fixed priority vs round-robin on req=1010
      req = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fp_gid", fp_gid, fp_g[i]);
         chk("rr_gid2", rr_gid, rr_g[i]);
         step();
         chk("fp_ack", fp_ack, 4'b1 << fp_g[i]);
         step();
         if (i == 1) req = 4'b1000;
      end
      req = '0;
      mem_ack = 1'b0;
      step();

      // timeout with no mem_ack: port 2, rdata[2] currently nonzero
      req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("to_strobe", rr_rd, 1);
         chk("to_noack", rr_ack, 0);
      end
      step();
      chk("to_ack", rr_ack, 4'b0100);
      chk("to_err", rr_err, 4'b0100);
      chk("to_rdata", rr_rdata[2], 0);
      chk("to_strobe_off", rr_rd, 0);
      chk("fp_no_tmo_ack", fp_ack, 0);
      chk("fp_no_tmo_rd", fp_rd, 1);
      req = '0;
      step();
      chk("to_ack_pulse", rr_ack, 0);

      // mem_ack on the last timeout cycle wins
      do_reset();
      req = 4'b0100;
      for (int i = 0; i < 5; i++) step();
      chk("tw_strobe", rr_rd, 1);
      mem_ack = 1'b1;
      mem_data_read = 32'h0BADF00D;
      step();
      chk("tw_ack", rr_ack, 4'b0100);
      chk("tw_err", rr_err, 0);
      chk("tw_rdata", rr_rdata[2], 32'h0BADF00D);
      chk("tw_fp_ack", fp_ack, 4'b0100);
      mem_ack = 1'b0;
      req = '0;
      step();

      // reset during ACCESS
      req = 4'b0010;
      addr[1] = 32'h444;
      step();
      chk("ra_gid", rr_gid, 1);
      chk("ra_strobe", rr_rd, 1);
      reset = 1'b0;
      mem_ack = 1'b1;
      req = '0;
      step();
      chk("ra_ack", rr_ack, 0);
      chk("ra_rd", rr_rd, 0);
      chk("ra_busy", rr_busy, 0);
      chk("ra_addr", rr_maddr, 0);
      chk("ra_gid0", rr_gid, 0);
      chk("ra_rdata", rr_rdata, 0);
      reset = 1'b1;
      step();
      chk("ra_ack_after", rr_ack, 0);
      chk("ra_busy_after", rr_busy, 0);
      mem_ack = 1'b0;
      req = 4'b1110;
      req = 4'b1111;
      step();
      chk("ra_next_gid", rr_gid, 0);
      chk("ra_next_rd", rr_rd, 1);
      req = 4'b1110;
      mem_ack = 1'b1;
      step();
      chk("ra_next_ack", rr_ack, 4'b0001);
      mem_ack = 1'b0;
      req = '0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
